// File: rtl/gpio_pkg.sv
// Shared definitions for the iomem GPIO bank: register offsets and the offset decoder.
package gpio_pkg;

  localparam int MAX_PINS = 32;

  localparam logic [7:0] GPIO_OFS_OUT  = 8'h00;
  localparam logic [7:0] GPIO_OFS_DIR  = 8'h04;
  localparam logic [7:0] GPIO_OFS_IN   = 8'h08;
  localparam logic [7:0] GPIO_OFS_EN   = 8'h0C;
  localparam logic [7:0] GPIO_OFS_EDGE = 8'h10;
  localparam logic [7:0] GPIO_OFS_STAT = 8'h14;

  typedef enum logic [2:0] {
    REG_OUT,
    REG_DIR,
    REG_IN,
    REG_EN,
    REG_EDGE,
    REG_STAT,
    REG_NONE
  } gpio_reg_e;

  // Byte lane bits [1:0] are ignored: every register is word aligned.
  function automatic gpio_reg_e gpio_decode(input logic [7:0] ofs);
    gpio_reg_e r;
    case ({ofs[7:2], 2'b00})
      GPIO_OFS_OUT:  r = REG_OUT;
      GPIO_OFS_DIR:  r = REG_DIR;
      GPIO_OFS_IN:   r = REG_IN;
      GPIO_OFS_EN:   r = REG_EN;
      GPIO_OFS_EDGE: r = REG_EDGE;
      GPIO_OFS_STAT: r = REG_STAT;
      default:       r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// One pin: SYNC_STAGES-deep input synchroniser plus optional edge detector.
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic edge_sel,
  input  logic arm,
  output logic sync,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic last_q, last_d;

      always_comb begin
        last_d = sync;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b0;
        else        last_q <= last_d;
      end

      // edge_sel=0 selects rising, 1 selects falling; arm masks the start-up transient.
      assign evt = arm & (edge_sel ? (last_q & ~sync) : (~last_q & sync));
    end else begin : g_no_edge
      logic unused_edge;
      assign unused_edge = edge_sel ^ arm;
      assign evt         = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/iomem_gpio_bank.sv
// GPIO bank on the PicoSoC iomem bus. Define GPIO_IRQ_EN to build the edge-interrupt
// registers (IRQ_EN/IRQ_EDGE/IRQ_STAT) and irq output; otherwise irq is tied low.
module iomem_gpio_bank
  import gpio_pkg::*;
#(
  parameter int          NUM_PINS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_PINS-1:0] pin_di,
  output logic [NUM_PINS-1:0] pin_do,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic                irq
);

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  function automatic logic [31:0] widen(input logic [NUM_PINS-1:0] v);
    logic [31:0] r;
    r              = '0;
    r[NUM_PINS-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  function automatic logic [NUM_PINS-1:0] merge(input logic [NUM_PINS-1:0] old,
                                                input logic [31:0] d,
                                                input logic [3:0] s);
    return NUM_PINS'((widen(old) & ~lane_mask(s)) | (d & lane_mask(s)));
  endfunction

  logic                sel, acc, wr;
  gpio_reg_e           reg_sel;
  logic [31:0]         rd_val;
  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] dir_q, dir_d;
  logic [NUM_PINS-1:0] in_w, evt_w, edge_w;
  logic                arm_w;

  assign sel     = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign acc     = sel & iomem_valid & ~ready_q;
  assign wr      = acc & (|iomem_wstrb);
  assign reg_sel = gpio_decode(iomem_addr[7:0]);

`ifdef GPIO_IRQ_EN
  localparam int                CNT_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  ARM_CNT = CNT_W'(SYNC_STAGES + 1);

  logic [NUM_PINS-1:0] en_q, en_d;
  logic [NUM_PINS-1:0] edge_q, edge_d;
  logic [NUM_PINS-1:0] stat_q, stat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Events stay masked until the sync chain and edge flop hold real pin data.
  assign arm_w  = (cnt_q == ARM_CNT);
  assign edge_w = edge_q;

  always_comb begin
    en_d   = en_q;
    edge_d = edge_q;
    stat_d = stat_q;
    cnt_d  = arm_w ? cnt_q : cnt_q + CNT_W'(1);
    if (wr) begin
      case (reg_sel)
        REG_EN:   en_d   = merge(en_q, iomem_wdata, iomem_wstrb);
        REG_EDGE: edge_d = merge(edge_q, iomem_wdata, iomem_wstrb);
        REG_STAT: stat_d = stat_q & ~NUM_PINS'(iomem_wdata & lane_mask(iomem_wstrb));
        default:  ;
      endcase
    end
    // A new event on a bit being cleared in the same cycle keeps it set.
    stat_d = stat_d | evt_w;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q   <= '0;
      edge_q <= '0;
      stat_q <= '0;
      cnt_q  <= '0;
    end else begin
      en_q   <= en_d;
      edge_q <= edge_d;
      stat_q <= stat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign irq = |(stat_q & en_q);
`else
  logic unused_evt;
  assign arm_w      = 1'b0;
  assign edge_w     = '0;
  assign unused_evt = ^evt_w;
  assign irq        = 1'b0;
`endif

  generate
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
      gpio_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_EN     (IRQ_BUILD)
      ) u_pin (
        .clk      (clk),
        .rst_n    (resetn),
        .din      (pin_di[i]),
        .edge_sel (edge_w[i]),
        .arm      (arm_w),
        .sync     (in_w[i]),
        .evt      (evt_w[i])
      );
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_OUT:  rd_val = widen(out_q);
      REG_DIR:  rd_val = widen(dir_q);
      REG_IN:   rd_val = widen(in_w);
`ifdef GPIO_IRQ_EN
      REG_EN:   rd_val = widen(en_q);
      REG_EDGE: rd_val = widen(edge_q);
      REG_STAT: rd_val = widen(stat_q);
`endif
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    ready_d = acc;
    rdata_d = acc ? rd_val : rdata_q;
    out_d   = out_q;
    dir_d   = dir_q;
    if (wr) begin
      case (reg_sel)
        REG_OUT: out_d = merge(out_q, iomem_wdata, iomem_wstrb);
        REG_DIR: dir_d = merge(dir_q, iomem_wdata, iomem_wstrb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      dir_q   <= '1;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign pin_do      = out_q;
  assign pin_oe      = ~dir_q;

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Scoreboarded bench for iomem_gpio_bank: directed register cases plus random traffic.
module tb_iomem_gpio_bank;

  localparam int          NP   = 8;
  localparam int          SS   = 2;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [31:0] PM   = 32'h0000_00FF;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          iomem_valid = 1'b0;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb = 4'h0;
  logic [31:0]   iomem_addr = 32'h0;
  logic [31:0]   iomem_wdata = 32'h0;
  logic [31:0]   iomem_rdata;
  logic [NP-1:0] pin_di = '0;
  logic [NP-1:0] pin_do, pin_oe;
  logic          irq;

  iomem_gpio_bank #(.NUM_PINS(NP), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .pin_di(pin_di), .pin_do(pin_do), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { bit chk; logic [31:0] exp; logic [31:0] addr; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  logic [31:0] m_out, m_dir, m_en, m_edge, m_stat, m_pins;
  logic [31:0] last_rd = 32'h0;
  bit prev_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: registers as plain words, addressed by word offset.
  function automatic logic [31:0] mref(input logic [31:0] a);
    case (a[7:0] & 8'hFC)
      8'h00: return m_out;
      8'h04: return m_dir;
      8'h08: return m_pins;
`ifdef GPIO_IRQ_EN
      8'h0C: return m_en;
      8'h10: return m_edge;
      8'h14: return m_stat;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] bytes_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = d[8*k +: 8];
    return m & PM;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] clr;
    clr = bytes_merge(32'h0, d, s);
    case (a[7:0] & 8'hFC)
      8'h00: m_out = bytes_merge(m_out, d, s);
      8'h04: m_dir = bytes_merge(m_dir, d, s);
`ifdef GPIO_IRQ_EN
      8'h0C: m_en   = bytes_merge(m_en, d, s);
      8'h10: m_edge = bytes_merge(m_edge, d, s);
      8'h14: m_stat = m_stat & ~clr;
`endif
      default: ;
    endcase
  endtask

  task automatic model_reset(input logic [31:0] pins);
    m_out = 0; m_dir = PM; m_en = 0; m_edge = 0; m_stat = 0; m_pins = pins & PM;
    last_rd = 0;
  endtask

  function automatic logic exp_irq();
`ifdef GPIO_IRQ_EN
    return |(m_stat & m_en);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_pins();
    check("pin_oe", {24'h0, pin_oe}, ~m_dir & PM);
    check("pin_do", {24'h0, pin_do}, m_out);
    check("irq", {31'h0, irq}, {31'h0, exp_irq()});
  endtask

  // Monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    if (iomem_ready) begin
      total++;
      if (prev_rdy) begin
        bad++;
        $display("FAIL ready_width: ready high on two consecutive cycles");
      end
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: got ready=1 expected no transfer");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) check($sformatf("rdata@%h", e.addr), iomem_rdata, e.exp);
      end
      last_rd = iomem_rdata;
    end
    prev_rdy = iomem_ready;
  end

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit   selx;
    int   n;
    exp_t e;
    selx = (a[31:8] == BASE[31:8]);
    @(posedge clk); #1;
    if (selx) begin
      e.chk = (s == 4'h0); e.exp = mref(a); e.addr = a;
      sb.push_back(e);
    end
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 4);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    total++;
    if (selx) begin
      if (!iomem_ready) begin
        bad++;
        $display("FAIL ready_timeout@%h: got no ready expected ready after 1 cycle", a);
        void'(sb.pop_back());
      end else if (n != 2) begin
        bad++;
        $display("FAIL latency@%h: got %0d cycles expected 1", a, n - 1);
      end
      if (s != 4'h0) model_write(a, d, s);
    end else begin
      if (iomem_ready) begin
        bad++;
        $display("FAIL unsel_ready@%h: got ready=1 expected 0", a);
      end
      check("unsel_rdata_hold", iomem_rdata, last_rd);
    end
  endtask

  task automatic set_pins(input logic [NP-1:0] v);
    logic [31:0] nw, rise, fall;
    @(posedge clk); #1;
    nw   = {24'h0, v};
    rise = ~m_pins & nw;
    fall = m_pins & ~nw;
`ifdef GPIO_IRQ_EN
    m_stat = m_stat | (((rise & ~m_edge) | (fall & m_edge)) & PM);
`endif
    pin_di = v;
    m_pins = nw;
    repeat (SS + 3) @(posedge clk);
  endtask

  task automatic read_all();
    for (int o = 0; o < 8'h1C; o += 4) bus(BASE + o, 32'h0, 4'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] rp;
    model_reset(32'h0);
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    check("rst_ready", {31'h0, iomem_ready}, 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    repeat (SS + 4) @(posedge clk);
    check_pins();

    // Reset values and unmapped offsets.
    read_all();
    bus(BASE + 32'h18, 32'h0, 4'h0);
    bus(BASE + 32'hFC, 32'h0, 4'h0);

    // Direction and output drive.
    bus(BASE + 32'h04, 32'h0000_000F, 4'hF); check_pins();
    bus(BASE + 32'h00, 32'h0000_00A5, 4'hF); check_pins();
    bus(BASE + 32'h00, 32'h0, 4'h0);

    // Byte strobes, then writes to read-only/unmapped offsets.
    bus(BASE + 32'h00, 32'h1234_5678, 4'b0001); check_pins();
    bus(BASE + 32'h02, 32'h0, 4'h0);
    bus(BASE + 32'h00, 32'h1234_56FF, 4'b1110); check_pins();
    bus(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
    bus(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF);
    bus(BASE + 32'h200, 32'h0000_0000, 4'hF); check_pins();
    read_all();

    // Rising edge on pin 3 with its interrupt enabled, then W1C.
    bus(BASE + 32'h0C, 32'h0000_0008, 4'hF);
    set_pins(8'h08);
    bus(BASE + 32'h08, 32'h0, 4'h0);
    bus(BASE + 32'h14, 32'h0, 4'h0); check_pins();
    bus(BASE + 32'h14, 32'h0000_0008, 4'hF); check_pins();
    bus(BASE + 32'h14, 32'h0, 4'h0);

    // Falling edge on pin 0 coinciding with the W1C of bit 0.
    bus(BASE + 32'h10, 32'h0000_0001, 4'hF);
    bus(BASE + 32'h0C, 32'h0000_0001, 4'hF);
    set_pins(8'h09);
    set_pins(8'h08);
    bus(BASE + 32'h14, 32'h0, 4'h0); check_pins();
    set_pins(8'h09);
    @(posedge clk); #1;
    pin_di = 8'h08;
    m_pins = 32'h08;
    repeat (SS - 1) @(posedge clk);
    bus(BASE + 32'h14, 32'h0000_0001, 4'hF);
`ifdef GPIO_IRQ_EN
    m_stat = m_stat | 32'h1;
`endif
    check_pins();
    repeat (SS + 3) @(posedge clk);
    bus(BASE + 32'h14, 32'h0, 4'h0);

    // Random traffic.
    for (int it = 0; it < 200; it++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = BASE + ($urandom_range(0, 7) * 4) + $urandom_range(0, 3);
      if (op <= 1) set_pins(NP'($urandom));
      else if (op <= 5) begin
        logic [3:0] s;
        s = 4'($urandom_range(1, 15));
        bus(a, $urandom, s);
      end else if (op <= 8) bus(a, 32'h0, 4'h0);
      else bus((op[0] ? 32'h0200_0000 : BASE + 32'h100) + ($urandom_range(0, 63) * 4), $urandom, 4'hF);
      check_pins();
    end

    // Reset asserted while a read is in flight: no ready, registers back to reset.
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = BASE + 32'h04; iomem_wstrb = 4'h0;
    #2 resetn = 1'b0;
    rp = NP'($urandom) | 8'h01;
    pin_di = rp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    iomem_valid = 1'b0;
    resetn = 1'b1;
    model_reset({24'h0, rp});
    check("rst2_rdata", iomem_rdata, 32'h0);
    check("rst2_irq", {31'h0, irq}, 32'h0);
    repeat (SS + 4) @(posedge clk);
    check("rst2_ready", {31'h0, iomem_ready}, 32'h0);
    check_pins();
    read_all();

    repeat (4) @(posedge clk);
    check("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
